// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and load/store,
// with LS-over-IF priority, one outstanding transaction and a timeout watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic                if_rsp_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_rsp_valid,
  output logic                ls_rsp_err,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  timeout;
  logic                  mem_req_next, mem_we_next;
  logic [ADDR_W-1:0]     mem_addr_next;
  logic [DATA_W-1:0]     mem_wdata_next;
  logic [DATA_W/8-1:0]   mem_be_next;
  logic                  if_rsp_valid_next, if_rsp_err_next;
  logic [DATA_W-1:0]     if_rdata_next;
  logic                  ls_rsp_valid_next, ls_rsp_err_next;
  logic [DATA_W-1:0]     ls_rdata_next;

  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ls_req)      state_next = BUSY_LS;
        else if (if_req) state_next = BUSY_IF;
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_rvalid || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Computes the next value of every registered output; ack wins over timeout.
  always_comb begin
    cnt_next          = cnt;
    mem_req_next      = mem_req;
    mem_we_next       = mem_we;
    mem_addr_next     = mem_addr;
    mem_wdata_next    = mem_wdata;
    mem_be_next       = mem_be;
    if_rsp_valid_next = 1'b0;
    if_rsp_err_next   = if_rsp_err;
    if_rdata_next     = if_rdata;
    ls_rsp_valid_next = 1'b0;
    ls_rsp_err_next   = ls_rsp_err;
    ls_rdata_next     = ls_rdata;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (ls_req) begin
          mem_req_next   = 1'b1;
          mem_we_next    = ls_we;
          mem_addr_next  = ls_addr;
          mem_wdata_next = ls_wdata;
          mem_be_next    = ls_be;
        end else if (if_req) begin
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          mem_wdata_next = '0;
          mem_be_next    = '1;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_rvalid || timeout) begin
          mem_req_next = 1'b0;
          cnt_next     = '0;
          if (state == BUSY_LS) begin
            ls_rsp_valid_next = 1'b1;
            ls_rsp_err_next   = !mem_rvalid;
            ls_rdata_next     = (mem_rvalid && !mem_we) ? mem_rdata : '0;
          end else begin
            if_rsp_valid_next = 1'b1;
            if_rsp_err_next   = !mem_rvalid;
            if_rdata_next     = mem_rvalid ? mem_rdata : '0;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_err   <= 1'b0;
      if_rdata     <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_err   <= 1'b0;
      ls_rdata     <= '0;
    end else begin
      cnt          <= cnt_next;
      mem_req      <= mem_req_next;
      mem_we       <= mem_we_next;
      mem_addr     <= mem_addr_next;
      mem_wdata    <= mem_wdata_next;
      mem_be       <= mem_be_next;
      if_rsp_valid <= if_rsp_valid_next;
      if_rsp_err   <= if_rsp_err_next;
      if_rdata     <= if_rdata_next;
      ls_rsp_valid <= ls_rsp_valid_next;
      ls_rsp_err   <= ls_rsp_err_next;
      ls_rdata     <= ls_rdata_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle
// plus literal expectations for latency, data and timeout length.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_rsp_valid, if_rsp_err;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [3:0]    ls_be = '0;
  logic          ls_rsp_valid, ls_rsp_err;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_err(if_rsp_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_err(ls_rsp_err),
    .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks on mem_req cycle number ack_delay+1; -1 never acks.
  int            ack_delay = 0;
  logic [DW-1:0] rd_val = '0;
  int            mem_cyc = 0;
  initial forever begin
    @(posedge clk); #1;
    if (mem_req && !rst) begin
      mem_rvalid = (ack_delay >= 0) && (mem_cyc == ack_delay);
      mem_rdata  = mem_rvalid ? rd_val : 32'hA5A5_0000 + DW'(mem_cyc);
      mem_cyc++;
    end else begin
      mem_rvalid = 1'b0;
      mem_cyc    = 0;
    end
  end

  int req_cycles = 0;
  always @(negedge clk) if (mem_req) req_cycles++;

  // Transaction-level model: owner 0 = none, 1 = IF, 2 = LS.
  int            m_owner, m_age;
  logic          m_req, m_we, m_if_v, m_if_e, m_ls_v, m_ls_e;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_d, m_ls_d;
  logic [3:0]    m_be;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_age = 0; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_if_v = 0; m_if_e = 0; m_if_d = '0; m_ls_v = 0; m_ls_e = 0; m_ls_d = '0;
    end else begin
      m_if_v = 0; m_ls_v = 0;
      if (m_owner == 0) begin
        if (ls_req) begin
          m_owner = 2; m_req = 1; m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_be = ls_be; m_age = 0;
        end else if (if_req) begin
          m_owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF; m_age = 0;
        end
      end else begin
        m_age++;
        if (mem_rvalid || m_age == TO) begin
          if (m_owner == 1) begin
            m_if_v = 1; m_if_e = !mem_rvalid; m_if_d = mem_rvalid ? mem_rdata : '0;
          end else begin
            m_ls_v = 1; m_ls_e = !mem_rvalid; m_ls_d = (mem_rvalid && !m_we) ? mem_rdata : '0;
          end
          m_owner = 0; m_req = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("mem_req", mem_req, m_req);
      if (m_req) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_be", mem_be, m_be);
      end
      chk("if_rsp_valid", if_rsp_valid, m_if_v);
      chk("ls_rsp_valid", ls_rsp_valid, m_ls_v);
      chk("if_rsp_err", if_rsp_err, m_if_e);
      chk("ls_rsp_err", ls_rsp_err, m_ls_e);
      chk("if_rdata", if_rdata, m_if_d);
      chk("ls_rdata", ls_rdata, m_ls_d);
    end
  end

  task automatic wait_rsp(input bit is_ls, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #2;
      if (is_ls ? ls_rsp_valid : if_rsp_valid) begin
        lat = n;
        if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got no response expected one within 40 cycles");
    end
  endtask

  int lat;
  initial begin
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rsp_valid", {if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err}, 0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 0);
    @(negedge clk); rst = 1'b0; model_on = 1'b1;
    @(posedge clk); #2;

    // IF-only read, ack on second mem_req cycle
    ack_delay = 1; rd_val = 32'h0050_0093;
    if_addr = 32'h0000_0010; if_req = 1'b1;
    wait_rsp(0, lat);
    chk("if_lat", lat, 3);
    chk("if_data", if_rdata, 32'h0050_0093);
    chk("if_err", if_rsp_err, 0);

    // Simultaneous requests: LS first, IF granted on the return-to-IDLE cycle
    ack_delay = 0; rd_val = 32'h1111_2222;
    ls_we = 1'b0; ls_addr = 32'h100; ls_be = 4'hF; ls_wdata = 32'h0;
    if_addr = 32'h0000_0040;
    @(posedge clk); #2;
    ls_req = 1'b1; if_req = 1'b1;
    wait_rsp(1, lat);
    chk("ls_min_lat", lat, 2);
    chk("ls_load_data", ls_rdata, 32'h1111_2222);
    chk("if_not_yet", if_rsp_valid, 0);
    wait_rsp(0, lat);
    chk("if_after_ls_lat", lat, 2);

    // Store with ack on the fourth mem_req cycle
    @(posedge clk); #2;
    ack_delay = 3; rd_val = 32'h1234_5678; req_cycles = 0;
    ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3; ls_req = 1'b1;
    wait_rsp(1, lat);
    chk("store_req_cycles", req_cycles, 4);
    chk("store_rdata", ls_rdata, 0);
    chk("store_err", ls_rsp_err, 0);

    // Timeout: memory never acks
    @(posedge clk); #2;
    ack_delay = -1; req_cycles = 0;
    ls_we = 1'b0; ls_addr = 32'h300; ls_req = 1'b1;
    wait_rsp(1, lat);
    chk("timeout_req_cycles", req_cycles, 16);
    chk("timeout_err", ls_rsp_err, 1);
    chk("timeout_rdata", ls_rdata, 0);
    ack_delay = 0; rd_val = 32'h0000_0013; if_addr = 32'h44; if_req = 1'b1;
    wait_rsp(0, lat);
    chk("post_timeout_if_lat", lat, 2);
    chk("post_timeout_if_err", if_rsp_err, 0);

    // Boundary: ack on the 16th mem_req cycle
    @(posedge clk); #2;
    ack_delay = 15; rd_val = 32'hCAFE_F00D; req_cycles = 0;
    ls_addr = 32'h400; ls_req = 1'b1;
    wait_rsp(1, lat);
    chk("boundary_req_cycles", req_cycles, 16);
    chk("boundary_err", ls_rsp_err, 0);
    chk("boundary_data", ls_rdata, 32'hCAFE_F00D);

    // Async reset in the middle of BUSY_IF
    ack_delay = -1; if_addr = 32'h80; if_req = 1'b1;
    repeat (3) @(posedge clk);
    #3; rst = 1'b1; #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_no_rsp", if_rsp_valid, 0);
    if_req = 1'b0;
    @(posedge clk); #3; rst = 1'b0;
    chk("post_rst_no_rsp", if_rsp_valid, 0);
    @(posedge clk); #2;
    ack_delay = 0; rd_val = 32'h0000_0297; if_addr = 32'h0; if_req = 1'b1;
    wait_rsp(0, lat);
    chk("post_rst_if_lat", lat, 2);
    chk("post_rst_if_data", if_rdata, 32'h0000_0297);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write) of the multi-cycle RV32I core.
- Allows one outstanding transaction at a time. Uses fixed LS-over-IF priority.
- Runs a per-transaction timeout watchdog and returns an error response when it expires.
- Sits between the control-unit-sequenced fetch/memory stages and the memory model.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT_CYCLES, 16, maximum number of cycles mem_req may be held before the transaction is aborted. Must be ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_rsp_valid
- if_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  one-cycle fetch completion pulse
- if_rsp_err  out  1  fetch timed out; qualified by if_rsp_valid
- if_rdata  out  DATA_W  fetched instruction
- ls_req  in  1  load/store request; held until ls_rsp_valid
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_be  in  DATA_W/8  byte enables
- ls_rsp_valid  out  1  one-cycle load/store completion pulse
- ls_rsp_err  out  1  load/store timed out; qualified by ls_rsp_valid
- ls_rdata  out  DATA_W  load data
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rvalid  in  1  memory ack (reads and writes); valid only while mem_req=1
- mem_rdata  in  DATA_W  read data; qualified by mem_rvalid

Behaviour:
- All outputs are registered.
- Reset (async, rst=1) values:
  - state=IDLE
  - all mem_* = 0
  - *_rsp_valid = 0, *_rsp_err = 0
  - *_rdata = 0
  - timeout counter = 0
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- IDLE:
  - ls_req=1 → BUSY_LS. Latch ls_we/ls_addr/ls_wdata/ls_be onto mem_*; mem_req=1 from the next cycle.
  - Else if_req=1 → BUSY_IF. mem_we=0, mem_addr=if_addr, mem_be=all ones, mem_wdata=0.
  - Both requests in the same cycle → LS wins. IF stays pending and is granted on the next IDLE cycle.
- BUSY_x:
  - mem_* are held stable. Requester inputs are ignored while busy (they were latched at grant).
  - Counter increments each cycle mem_req=1.
  - mem_rvalid=1 → next cycle: x_rsp_valid=1, x_rsp_err=0, x_rdata=mem_rdata (stores: x_rdata=0). Also mem_req=0, counter=0, state=IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without mem_rvalid → next cycle: x_rsp_valid=1, x_rsp_err=1, x_rdata=0, mem_req=0, state=IDLE.
  - mem_rvalid and timeout in the same cycle → mem_rvalid takes precedence (no error).
- Latency:
  - Request sampled in IDLE at cycle N → mem_req=1 at N+1.
  - mem_rvalid at cycle M → rsp_valid at M+1.
  - Minimum request-to-response latency is 2 cycles when mem_rvalid is asserted in the first cycle of mem_req.
- Back-to-back: the return-to-IDLE cycle (M+1) is itself an IDLE cycle and may grant. The requester drops req on seeing rsp_valid, so the arbiter re-grants only requests that are still high at M+1. An IF request still high at M+1 because it was pending behind LS is granted at M+1.
- rsp_valid is always a single-cycle pulse. if_rsp_valid and ls_rsp_valid are never asserted together.
- rdata and err hold their last value until the next response.
- A requester deasserting req while busy has no effect: the transaction completes, and the response pulse is still issued.
- Reset mid-transaction aborts immediately. No response is issued, and mem_req drops asynchronously.
- mem_rvalid in IDLE is ignored.
- Counter width is clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps.

Test Plan:
- IF-only read: if_req=1, if_addr=0x0000_0010, memory acks 1 cycle after mem_req with 0x0050_0093 → mem_req at N+1 with addr 0x10, we=0, be=0xF; if_rsp_valid one pulse, if_rdata=0x0050_0093, err=0.
- Simultaneous requests: if_req=1, ls_req=1 (load, addr 0x100) in the same IDLE cycle → LS served first (mem_addr=0x100); IF granted on the return-to-IDLE cycle (mem_req next cycle, addr=if_addr); responses are never concurrent.
- Store: ls_we=1, ls_addr=0x200, ls_wdata=0xDEAD_BEEF, ls_be=0x3, memory acks after 3 cycles → mem_* stable for all 4 mem_req cycles; ls_rsp_valid pulse, ls_rdata=0, err=0.
- Timeout: LS load, memory never acks, TIMEOUT_CYCLES=16 → mem_req high exactly 16 cycles; ls_rsp_valid=1, ls_rsp_err=1, ls_rdata=0; state IDLE; next if_req served normally.
- Boundary: mem_rvalid on the final (16th) cycle → ls_rsp_err=0 with data returned.
- Async reset mid-BUSY_IF (rst asserted between clock edges) → mem_req=0 immediately, no if_rsp_valid; after release, a new if_req is served from IDLE.
